id_scoreboard_ctrl: RTL and testbench
=====================================

ID_SCOREBOARD_CTRL -- requirements
Module: id_scoreboard_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have: id_valid_i  in  1  decoded instruction present in ID; id_ready_o  out  1  ID instruction consumed this cycle.
REQ-004 SHALL have: rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each; rs1_used_i, rs2_used_i, rd_we_i  in  1 each  operand/destination usage flags from decoder.
REQ-005 SHALL have: ex_valid_o  out  1  issue to ID-EX register; ex_ready_i  in  1  EX accepts.
REQ-006 SHALL have: wb_valid_i  in  1, wb_addr_i  in  5  register-file write-back completing.
REQ-007 SHALL have: flush_i  in  1  discard ID instruction; state_o  out  2  FSM state; busy_o  out  32  scoreboard bits.

Function
REQ-008 Scoreboard: busy[31:0], one bit per architectural register; busy[0] SHALL be constant 0.
REQ-009 Hazard = (rs1_used_i & busy[rs1]) | (rs2_used_i & busy[rs2]) | (rd_we_i & rd!=0 & busy[rd]) (RAW plus WAW).
REQ-010 ex_valid_o = id_valid_i & !hazard & !flush_i & state!=FLUSH; combinational, same cycle.
REQ-011 Issue occurs when ex_valid_o & ex_ready_i; id_ready_o = issue | flush_i | state==FLUSH.
REQ-012 On issue with rd_we_i=1 and rd!=0, busy[rd] SHALL set at next edge.
REQ-013 On wb_valid_i with wb_addr_i!=0, busy[wb_addr_i] SHALL clear at next edge; wb to non-busy register or x0 is ignored.
REQ-014 Same-cycle set and clear of same register: set wins (newer pending write).
REQ-015 FSM states RUN=0, STALL=1, FLUSH=2; encoding 3 unused, SHALL recover to RUN.
REQ-016 Transitions: any state -> FLUSH on flush_i (highest priority); FLUSH -> RUN after exactly one cycle; RUN -> STALL when id_valid_i & (hazard | !ex_ready_i) & no issue; STALL -> RUN on issue or !id_valid_i.
REQ-017 flush_i SHALL NOT modify busy bits; in-flight write-backs still clear them.
REQ-018 Instruction held in STALL SHALL see updated busy bits each cycle; no issue lost or duplicated.

Reset
REQ-019 While rst_i=1 at an edge: busy=0, state=RUN; ex_valid_o and id_ready_o SHALL be 0 during any cycle rst_i is high.
REQ-020 Reset mid-stall or mid-flush SHALL abandon the operation; first post-reset cycle behaves as RUN with empty scoreboard.

Configuration
REQ-021 Macro MILANO_WB_BYPASS_EN: defined -> hazard evaluation treats busy[wb_addr_i] as clear in the same cycle wb_valid_i is high (issue same cycle as write-back).
REQ-022 Undefined -> hazard uses registered busy only; dependent instruction issues one cycle after write-back.

Structure
REQ-023 milano_pkg SHALL hold REG_NUM=32, REG_ADDR_W=5, and typedef enum ctrl_state_e {RUN, STALL, FLUSH}.
REQ-024 Busy array with set/clear/priority logic SHALL be sub-module milano_busy_table; FSM and handshake stay in id_scoreboard_ctrl.

Verification
REQ-025 Reset, then id_valid_i=1, rd=5, rd_we_i=1, ex_ready_i=1 -> ex_valid_o=1 same cycle, busy_o=0x20 next cycle.
REQ-026 busy[5]=1, instr rs1=5 rs1_used=1 -> ex_valid_o=0, state STALL; wb_valid_i=1 wb_addr=5 -> issue same cycle with bypass, next cycle without.
REQ-027 Issue rd=7 and wb_addr=7 in same cycle with busy[7]=1 -> busy[7] remains 1.
REQ-028 STALL state, flush_i=1 -> ex_valid_o=0, id_ready_o=1, state FLUSH one cycle then RUN; busy_o unchanged.
REQ-029 rd=0, rd_we_i=1 issue; wb_addr=0 -> busy_o stays 0; rs1=0 never hazards.
REQ-030 rst_i asserted during STALL with busy=0xFFFE -> next cycle busy_o=0, state_o=RUN, ex_valid_o=0 while rst_i high.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared constants and FSM state type for the ID-stage scoreboard controller.
package milano_pkg;
  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;
endpackage

// File: rtl/milano_busy_table.sv
// Per-register pending-write bits; a set and a clear on the same register
// in one cycle leaves the bit set because the set belongs to the newer write.
module milano_busy_table
  import milano_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [REG_NUM-1:0]    busy
);
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] clr_mask;
  logic [REG_NUM-1:0] busy_reg;
  logic [REG_NUM-1:0] busy_next;

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_decode
    assign set_mask[gi] = set_en && (set_addr == REG_ADDR_W'(gi));
    assign clr_mask[gi] = clr_en && (clr_addr == REG_ADDR_W'(gi));
  end

  // x0 is hardwired zero, so its bit can never become pending.
  assign busy_next = ((busy_reg & ~clr_mask) | set_mask) & ~REG_NUM'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign busy = busy_reg;
endmodule

// File: rtl/id_scoreboard_ctrl.sv
// ID-stage issue control: RAW/WAW hazard check against the busy table, issue
// handshake and RUN/STALL/FLUSH FSM. MILANO_WB_BYPASS_EN enables write-back bypass.
module id_scoreboard_ctrl
  import milano_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic                  rd_we_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic                  flush_i,
  output logic [1:0]            state_o,
  output logic [REG_NUM-1:0]    busy_o
);
  ctrl_state_e        state_reg;
  ctrl_state_e        state_next;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_eff;
  logic               hazard;
  logic               issue;
  logic               set_en;
  logic               clr_en;

  assign set_en = issue && rd_we_i && (rd_addr_i != '0);
  assign clr_en = wb_valid_i && (wb_addr_i != '0);

  milano_busy_table u_busy_table (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (set_en),
    .set_addr (rd_addr_i),
    .clr_en   (clr_en),
    .clr_addr (wb_addr_i),
    .busy     (busy)
  );

  always_comb begin
    busy_eff = busy;
`ifdef MILANO_WB_BYPASS_EN
    // A completing write-back releases its register for this cycle's check.
    if (wb_valid_i) busy_eff[wb_addr_i] = 1'b0;
`endif
    hazard = (rs1_used_i && busy_eff[rs1_addr_i]) ||
             (rs2_used_i && busy_eff[rs2_addr_i]) ||
             (rd_we_i && (rd_addr_i != '0) && busy_eff[rd_addr_i]);
    ex_valid_o = !rst_i && id_valid_i && !hazard && !flush_i && (state_reg != FLUSH);
    issue      = ex_valid_o && ex_ready_i;
    id_ready_o = !rst_i && (issue || flush_i || (state_reg == FLUSH));
  end

  always_comb begin
    state_next = RUN;
    case (state_reg)
      RUN:     state_next = (id_valid_i && !issue) ? STALL : RUN;
      STALL:   state_next = (issue || !id_valid_i) ? RUN : STALL;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
    if (flush_i) state_next = FLUSH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  assign state_o = state_reg;
  assign busy_o  = busy;
endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Randomized plus directed bench for id_scoreboard_ctrl against a pending-write
// reference model; honours MILANO_WB_BYPASS_EN when defined for the build.
module tb_id_scoreboard_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        rs1_used_i, rs2_used_i, rd_we_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic        flush_i;
  logic [1:0]  state_o;
  logic [31:0] busy_o;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  bit pend[32];
  int m_state;
  logic obs_exv, obs_idr;

  always #5 clk_i = ~clk_i;

  id_scoreboard_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .id_valid_i (id_valid_i),
    .id_ready_o (id_ready_o),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rd_addr_i  (rd_addr_i),
    .rs1_used_i (rs1_used_i),
    .rs2_used_i (rs2_used_i),
    .rd_we_i    (rd_we_i),
    .ex_valid_o (ex_valid_o),
    .ex_ready_i (ex_ready_i),
    .wb_valid_i (wb_valid_i),
    .wb_addr_i  (wb_addr_i),
    .flush_i    (flush_i),
    .state_o    (state_o),
    .busy_o     (busy_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  // One clock cycle: drive inputs, compare combinational outputs and
  // registered state against the model, then step the model.
  task automatic cyc(input bit rst, input bit idv, input bit [4:0] a1, input bit [4:0] a2,
                     input bit [4:0] ad, input bit u1, input bit u2, input bit we,
                     input bit exr, input bit wbv, input bit [4:0] wba, input bit fl);
    bit eff[32];
    bit hz, ev, ir, iss;
    int ns;
    @(negedge clk_i);
    rst_i = rst; id_valid_i = idv; rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = ad;
    rs1_used_i = u1; rs2_used_i = u2; rd_we_i = we; ex_ready_i = exr;
    wb_valid_i = wbv; wb_addr_i = wba; flush_i = fl;
    #1;
    eff = pend;
`ifdef MILANO_WB_BYPASS_EN
    if (wbv) eff[wba] = 1'b0;
`endif
    hz  = (u1 && eff[a1]) || (u2 && eff[a2]) || (we && ad != 0 && eff[ad]);
    ev  = !rst && idv && !hz && !fl && m_state != 2;
    iss = ev && exr;
    ir  = !rst && (iss || fl || m_state == 2);
    obs_exv = ex_valid_o;
    obs_idr = id_ready_o;
    check_val("ex_valid", ex_valid_o, ev);
    check_val("id_ready", id_ready_o, ir);
    check_val("state", state_o, m_state);
    check_val("busy", busy_o, pend_vec());
    $display("cyc %0d rst=%0d idv=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d/%0d exr=%0d wb=%0d/%0d fl=%0d -> exv=%0d idr=%0d st=%0d busy=%08h",
             ncyc, rst, idv, a1, u1, a2, u2, ad, we, exr, wbv, wba, fl,
             ex_valid_o, id_ready_o, state_o, busy_o);
    if (rst) begin
      ns = 0;
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    end else begin
      if (fl)                ns = 2;
      else if (m_state == 0) ns = (idv && !iss) ? 1 : 0;
      else if (m_state == 1) ns = (iss || !idv) ? 0 : 1;
      else                   ns = 0;
      if (wbv && wba != 0) pend[wba] = 1'b0;
      if (iss && we && ad != 0) pend[ad] = 1'b1;
    end
    m_state = ns;
    ncyc++;
    @(posedge clk_i);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic put_rd(input bit [4:0] r);
    cyc(0, 1, 0, 0, r, 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic do_wb(input bit [4:0] a);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, a, 0);
  endtask

  bit        hold;
  bit        r_idv, r_u1, r_u2, r_we, r_exr, r_wbv, r_fl, r_rst;
  bit [4:0]  r_a1, r_a2, r_ad, r_wba;
  int        start;

  initial begin
    rst_i = 1; id_valid_i = 1; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 5;
    rs1_used_i = 0; rs2_used_i = 0; rd_we_i = 1; ex_ready_i = 1;
    wb_valid_i = 0; wb_addr_i = 0; flush_i = 0;
    m_state = 0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_busy", busy_o, 32'h0);
    check_val("rst_state", state_o, 2'd0);
    check_val("rst_exv", ex_valid_o, 1'b0);
    check_val("rst_idr", id_ready_o, 1'b0);

    // First issue after reset sets busy[5].
    put_rd(5);
    check_val("r025_exv", obs_exv, 1'b1);
    #1 check_val("r025_busy", busy_o, 32'h20);

    // RAW stall on x5 resolved by write-back.
    cyc(0, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    check_val("r026_stall_exv", obs_exv, 1'b0);
    #1 check_val("r026_state", state_o, 2'd1);
    cyc(0, 1, 5, 0, 0, 1, 0, 0, 1, 1, 5, 0);
`ifdef MILANO_WB_BYPASS_EN
    check_val("r026_bypass_exv", obs_exv, 1'b1);
    idle();
`else
    check_val("r026_wb_exv", obs_exv, 1'b0);
    cyc(0, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    check_val("r026_late_exv", obs_exv, 1'b1);
`endif

    // Issue to x7 while x7 write-back completes.
    put_rd(7);
    cyc(0, 1, 0, 0, 7, 0, 0, 1, 1, 1, 7, 0);
`ifdef MILANO_WB_BYPASS_EN
    #1 check_val("r027_busy7", busy_o[7], 1'b1);
`else
    #1 check_val("r027_busy_cleared", busy_o, 32'h0);
    put_rd(7);
    #1 check_val("r027_busy7", busy_o[7], 1'b1);
`endif
    do_wb(7);

    // Flush out of STALL.
    put_rd(5);
    cyc(0, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    check_val("r028_exv", obs_exv, 1'b0);
    check_val("r028_idr", obs_idr, 1'b1);
    #1 check_val("r028_state_flush", state_o, 2'd2);
    idle();
    check_val("r028_flush_idr", obs_idr, 1'b1);
    #1 check_val("r028_state_run", state_o, 2'd0);
    check_val("r028_busy", busy_o, 32'h20);

    // x0 is never tracked.
    do_wb(5);
    put_rd(0);
    check_val("r029_exv", obs_exv, 1'b1);
    do_wb(0);
    #1 check_val("r029_busy", busy_o, 32'h0);
    put_rd(3);
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    check_val("r029_rs1_x0", obs_exv, 1'b1);
    do_wb(3);

    // Reset in the middle of a stall with x1..x15 pending.
    for (int r = 1; r < 16; r++) put_rd(5'(r));
    #1 check_val("r030_busy_pre", busy_o, 32'h0000FFFE);
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    #1 check_val("r030_state_pre", state_o, 2'd1);
    cyc(1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    check_val("r030_rst_exv", obs_exv, 1'b0);
    check_val("r030_rst_idr", obs_idr, 1'b0);
    #1 check_val("r030_busy", busy_o, 32'h0);
    check_val("r030_state", state_o, 2'd0);

    // Random traffic; a presented instruction is held until consumed.
    hold = 0;
    r_idv = 0; r_a1 = 0; r_a2 = 0; r_ad = 0; r_u1 = 0; r_u2 = 0; r_we = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        r_idv = ($urandom_range(3) != 0);
        r_a1  = 5'($urandom_range(7));
        r_a2  = 5'($urandom_range(7));
        r_ad  = 5'($urandom_range(7));
        r_u1  = $urandom_range(1) == 1;
        r_u2  = $urandom_range(1) == 1;
        r_we  = ($urandom_range(3) != 0);
      end
      r_exr = ($urandom_range(3) != 0);
      r_fl  = ($urandom_range(24) == 0);
      r_rst = ($urandom_range(149) == 0);
      r_wbv = 0;
      r_wba = 5'($urandom_range(31));
      if ($urandom_range(2) == 0) begin
        r_wbv = 1;
        start = $urandom_range(31);
        for (int k = 0; k < 32; k++)
          if (pend[(start + k) % 32]) r_wba = 5'((start + k) % 32);
      end else if ($urandom_range(15) == 0) begin
        r_wbv = 1;
      end
      cyc(r_rst, r_idv, r_a1, r_a2, r_ad, r_u1, r_u2, r_we, r_exr, r_wbv, r_wba, r_fl);
      hold = r_idv && !obs_idr && !r_rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
